serial_adder: RTL and testbench

Bit-serial two-operand adder built around a single 1-bit full-adder cell and a carry flip-flop. It accepts WIDTH-bit operands on a valid/ready handshake and processes one bit per cycle, LSB first. It returns the WIDTH-bit sum and carry-out on an output valid/ready handshake. It is the sequential consumer of the full-adder cell's S/Co outputs, used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fulladder.sv | 14 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width calculation.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int WIDTH_DEFAULT = 8;

   // Counter must hold 0..WIDTH-1; keep at least one bit for degenerate widths.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell: S = X ^ Y ^ Ci, Co = majority(X, Y, Ci).
// Purely combinational, no state.
module fulladder (
   input  logic X,
   input  logic Y,
   input  logic Ci,
   output logic S,
   output logic Co
);

   assign S  = X ^ Y ^ Ci;
   assign Co = (X & Y) | (Ci & (X ^ Y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one full-adder cell, LSB first; optional ovf port via SERIAL_ADDER_OVF_EN.
// Latency: accept edge plus WIDTH edges to out_valid (DONE entered on the last compute edge).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sha_q;
   logic [WIDTH-1:0] shb_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q;
   logic             cout_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   fulladder u_fa (
      .X  (sha_q[0]),
      .Y  (shb_q[0]),
      .Ci (carry_q),
      .S  (fa_s),
      .Co (fa_co)
   );

   assign sum_d    = {fa_s, sum_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sha_q   <= a;
                  shb_q   <= b;
                  carry_q <= cin;
                  sum_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= fa_co;
               sha_q   <= sha_q >> 1;
               shb_q   <= shb_q >> 1;
               // Counter parks at WIDTH-1; it is only cleared by the next accept.
               if (last_bit) begin
                  cout_q  <= fa_co;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // In the MSB cycle carry_q is the carry into the sign bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_bit) begin
         ovf_q <= carry_q ^ fa_co;
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors with hand-computed {ovf,cout,sum}.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;
   int sent   = 0;
   int got    = 0;
   bit stim_done = 1'b0;

   // Expected entry layout: {ovf, cout, sum[7:0]}
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Monitor: inputs change at posedge+1, so the negedge value predicts the handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [9:0] e;
         got++;
         if (exp_q.size() == 0) begin
            timeout("unexpected_result");
         end else begin
            e = exp_q.pop_front();
            chk("result", 64'({cout, sum}), 64'(e[8:0]));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 64'(ovf), 64'(e[9]));
`endif
         end
      end
   end

   // Called at posedge+1; returns at accept edge+1.
   task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                       input logic [9:0] e, input bit push);
      int n = 0;
      a = ta; b = tbv; cin = tc; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         timeout("accept");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) begin
         exp_q.push_back(e);
         sent++;
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) timeout("drain");
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid) timeout("out_valid");
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      @(posedge clk); #1;

      // Latency counted with the accept edge as edge 1.
      send(8'h35, 8'h4A, 1'b0, 10'h07F, 1'b1);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", 64'(lat), 64'd9);
      @(posedge clk); #1;
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
      chk("out_valid_after_hs", 64'(out_valid), 64'd0);

      send(8'hFF, 8'h01, 1'b0, 10'h100, 1'b1);
      send(8'h7F, 8'h01, 1'b0, 10'h280, 1'b1);
      drain();

      // Stall: result must hold for 20 cycles.
      out_ready = 1'b0;
      send(8'hFF, 8'hFF, 1'b1, 10'h1FF, 1'b1);
      wait_out_valid();
      repeat (20) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_result", 64'({cout, sum}), 64'h1FF);
      end
      out_ready = 1'b1;
      drain();

      // Operand churn with in_valid high during RUN.
      send(8'h5A, 8'h0F, 1'b1, 10'h06A, 1'b1);
      in_valid = 1'b1; a = 8'h11; b = 8'hEE; cin = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         chk("run_in_ready", 64'(in_ready), 64'd0);
         chk("run_busy", 64'(busy), 64'd1);
         a = ~a; b = ~b; cin = ~cin;
      end
      in_valid = 1'b0;
      drain();

      // Reset in RUN cycle 4 discards the transaction.
      send(8'h33, 8'h44, 1'b0, 10'h077, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_sum", 64'(sum), 64'd0);
      chk("mid_rst_cout", 64'(cout), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'h10, 8'h20, 1'b0, 10'h030, 1'b1);
      drain();

      // Back-to-back with random out_ready stalls.
      fork
         begin
            send(8'h80, 8'h80, 1'b0, 10'h300, 1'b1);
            send(8'hAA, 8'h55, 1'b1, 10'h100, 1'b1);
            send(8'h00, 8'h00, 1'b1, 10'h001, 1'b1);
            send(8'hC8, 8'h64, 1'b0, 10'h12C, 1'b1);
            send(8'h40, 8'h40, 1'b0, 10'h280, 1'b1);
            send(8'h01, 8'hFE, 1'b0, 10'h0FF, 1'b1);
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("result_count", 64'(got), 64'(sent));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
